vga_csr_bank: RTL and testbench
===============================

Name: vga_csr_bank

Overview:
Native-side control/status register bank sitting directly downstream of vga_axil_slave_fsm. It consumes that block's native write/read strobes and returns read data on its data_i input. It holds VGA timing/config registers as shadow/active pairs, with commit on frame boundary, plus sticky W1C status, a frame counter and an interrupt output for the timing core.

Parameters:
NATIVE_ADDR_WIDTH, 4, word-address width of the native bus (matches native_addr_t in vga_axil_pkg)
DATA_WIDTH, 32, native data width (matches axil_data_t)
ID_VALUE, 32'h5647_4101, constant returned by the ID register

Ports:
clk_i  in  1  system clock
arst_i  in  1  asynchronous, active-high reset
write_en_i  in  1  native write strobe (from write_en_o)
addr_write_i  in  NATIVE_ADDR_WIDTH  native write word address
wdata_i  in  DATA_WIDTH  native write data
read_en_i  in  1  native read strobe (from read_en_sync_o)
addr_read_i  in  NATIVE_ADDR_WIDTH  native read word address
rdata_o  out  DATA_WIDTH  read data to slave FSM data_i, registered
frame_start_i  in  1  one-cycle pulse from timing core at start of frame
underflow_i  in  1  one-cycle pulse, pixel FIFO underflow
ctrl_o  out  3  active CTRL {irq_en, test_pattern, enable}
hactive_o  out  12  active horizontal resolution
vactive_o  out  12  active vertical resolution
irq_o  out  1  interrupt, level

Behaviour:
- Clock/reset: single clock clk_i; arst_i asynchronous, active-high; all flops clear on assertion and release synchronously to clk_i.
- Register map (word addresses):
  - 0 CTRL, RW, bits [2:0]
  - 1 HACTIVE, RW, [11:0]
  - 2 VACTIVE, RW, [11:0]
  - 3 STATUS, W1C, bit0 frame_done, bit1 underflow
  - 4 FRAME_CNT, RO, 32 bits
  - 5 ID, RO, ID_VALUE
  - 6..max unmapped.
- Reset values: shadow and active CTRL = 0; HACTIVE = 640; VACTIVE = 480; STATUS = 0; FRAME_CNT = 0; rdata_o = 0; irq_o = 0.
- Write:
  - On a clk_i edge with write_en_i=1, the RW target's shadow updates with wdata_i masked to field width; unused bits read as 0.
  - RO and unmapped writes are ignored.
  - STATUS write clears each bit where wdata_i bit = 1.
- Commit:
  - Active copy loads shadow on any cycle where frame_start_i=1 or active CTRL.enable=0.
  - So while disabled, writes take effect one cycle after the write edge.
  - While enabled, writes take effect after the next frame_start_i.
  - Same-cycle write and frame_start_i: active takes the pre-write shadow; the new value commits at the following frame_start_i, or immediately if the resulting active enable=0.
- Status:
  - frame_start_i sets frame_done; underflow_i sets underflow.
  - Hardware set wins over a same-cycle W1C clear of the same bit.
- FRAME_CNT increments on each frame_start_i, regardless of enable; wraps 0xFFFF_FFFF to 0.
- Read:
  - read_en_i=1 at edge N: rdata_o holds the addressed value after edge N (1-cycle latency); it holds its value when read_en_i=0.
  - Unmapped reads return 0.
  - CTRL/HACTIVE/VACTIVE reads return the shadow.
  - Same-cycle read and write to the same address return the pre-write value.
- irq_o = registered (active irq_en & (frame_done | underflow)).
  - Updates one cycle after the status/ctrl change.
  - Deasserts one cycle after the W1C clear that empties STATUS.
- Reset mid-operation: all state returns to reset values immediately; no pending commit survives.

Decomposition:
- vga_axil_pkg gains:
  - a csr_addr_e enum (CTRL, HACTIVE, VACTIVE, STATUS, FRAME_CNT, ID)
  - a vga_ctrl_t packed struct {irq_en, test_pattern, enable}
  - reset-value localparams
  - a STATUS bit-index enum
- One sub-module, vga_csr_shadow_reg (parameterised width/reset value, shadow+active pair with commit input), instantiated three times.
- Status, counter and read mux stay in the top level.

Test Plan:
- Reset, read addrs 0..5 -> 0, 640, 480, 0, 0, ID_VALUE; read addr 7 -> 0; irq_o = 0.
- Enable=0, write HACTIVE=0x320 -> hactive_o=800 one cycle after the write edge. Write CTRL=0x1, then VACTIVE=600 -> vactive_o stays 480 until the next frame_start_i pulse, then 600.
- Write VACTIVE=0x258 on the same cycle as frame_start_i with enable=1 -> vactive_o unchanged; it becomes 600 at the next frame_start_i.
- CTRL=0x5, pulse underflow_i -> STATUS=0x2, irq_o=1. Write STATUS=0x2 on the same cycle as another underflow_i -> STATUS remains 0x2. Write STATUS=0x2 alone -> STATUS=0, irq_o=0 one cycle later.
- Preload FRAME_CNT near wrap via 2^32-1 pulses (force/backdoor acceptable) -> read 0xFFFF_FFFF, one more pulse -> 0.
- Write CTRL=0x7 and read CTRL in the same cycle -> rdata_o=old value. Assert arst_i mid-frame -> all outputs return to reset values with no clock edge required.

Source files
------------

// File: rtl/vga_axil_pkg.sv
// Shared types for the VGA AXI-lite control path: native bus types, the CSR
// address map, the CTRL field layout and register reset values.
package vga_axil_pkg;

   localparam int NATIVE_ADDR_W = 4;
   localparam int AXIL_DATA_W   = 32;

   typedef logic [NATIVE_ADDR_W-1:0] native_addr_t;
   typedef logic [AXIL_DATA_W-1:0]   axil_data_t;

   typedef enum logic [NATIVE_ADDR_W-1:0] {
      CSR_CTRL      = 4'd0,
      CSR_HACTIVE   = 4'd1,
      CSR_VACTIVE   = 4'd2,
      CSR_STATUS    = 4'd3,
      CSR_FRAME_CNT = 4'd4,
      CSR_ID        = 4'd5
   } csr_addr_e;

   typedef struct packed {
      logic irq_en;
      logic test_pattern;
      logic enable;
   } vga_ctrl_t;

   typedef enum int unsigned {
      STAT_FRAME_DONE = 0,
      STAT_UNDERFLOW  = 1
   } status_bit_e;

   localparam int CTRL_W    = 3;
   localparam int HACTIVE_W = 12;
   localparam int VACTIVE_W = 12;
   localparam int STATUS_W  = 2;

   localparam logic [CTRL_W-1:0]    CTRL_RST    = '0;
   localparam logic [HACTIVE_W-1:0] HACTIVE_RST = 12'd640;
   localparam logic [VACTIVE_W-1:0] VACTIVE_RST = 12'd480;

endpackage

// File: rtl/vga_csr_shadow_reg.sv
// Shadow/active register pair: software writes the shadow, the active copy
// picks up the shadow's current (pre-write) value on each commit cycle.
module vga_csr_shadow_reg #(
   parameter int               WIDTH       = 12,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_we,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_commit,
   output logic [WIDTH-1:0] o_shadow,
   output logic [WIDTH-1:0] o_active
);

   logic [WIDTH-1:0] r_shadow;
   logic [WIDTH-1:0] r_active;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_shadow <= RESET_VALUE;
         r_active <= RESET_VALUE;
      end else begin
         if (i_we)
            r_shadow <= i_wdata;
         if (i_commit)
            r_active <= r_shadow;
      end
   end

   assign o_shadow = r_shadow;
   assign o_active = r_active;

endmodule

// File: rtl/vga_csr_bank.sv
// Native-side CSR bank for the VGA timing core: shadowed timing/config
// registers committed at frame boundaries, W1C status, frame counter, IRQ.
module vga_csr_bank
   import vga_axil_pkg::*;
#(
   parameter int          NATIVE_ADDR_WIDTH = 4,
   parameter int          DATA_WIDTH        = 32,
   parameter logic [31:0] ID_VALUE          = 32'h5647_4101
) (
   input  logic                         clk_i,
   input  logic                         arst_i,
   input  logic                         write_en_i,
   input  logic [NATIVE_ADDR_WIDTH-1:0] addr_write_i,
   input  logic [DATA_WIDTH-1:0]        wdata_i,
   input  logic                         read_en_i,
   input  logic [NATIVE_ADDR_WIDTH-1:0] addr_read_i,
   output logic [DATA_WIDTH-1:0]        rdata_o,
   input  logic                         frame_start_i,
   input  logic                         underflow_i,
   output logic [2:0]                   ctrl_o,
   output logic [11:0]                  hactive_o,
   output logic [11:0]                  vactive_o,
   output logic                         irq_o
);

   logic                  w_wr_ctrl;
   logic                  w_wr_hactive;
   logic                  w_wr_vactive;
   logic                  w_wr_status;
   logic                  w_commit;
   logic [CTRL_W-1:0]     w_ctrl_shadow;
   logic [CTRL_W-1:0]     w_ctrl_active_bits;
   vga_ctrl_t             w_ctrl_active;
   logic [HACTIVE_W-1:0]  w_hactive_shadow;
   logic [VACTIVE_W-1:0]  w_vactive_shadow;
   logic [STATUS_W-1:0]   w_status_set;
   logic [STATUS_W-1:0]   w_status_clr;
   logic [DATA_WIDTH-1:0] w_rdata_next;
   logic                  w_unused_wdata;

   logic [STATUS_W-1:0]   r_status;
   logic [31:0]           r_frame_cnt;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_irq;

   assign w_wr_ctrl    = write_en_i && (addr_write_i == NATIVE_ADDR_WIDTH'(CSR_CTRL));
   assign w_wr_hactive = write_en_i && (addr_write_i == NATIVE_ADDR_WIDTH'(CSR_HACTIVE));
   assign w_wr_vactive = write_en_i && (addr_write_i == NATIVE_ADDR_WIDTH'(CSR_VACTIVE));
   assign w_wr_status  = write_en_i && (addr_write_i == NATIVE_ADDR_WIDTH'(CSR_STATUS));

   // While the core is disabled, shadows flow straight through every cycle.
   assign w_ctrl_active = vga_ctrl_t'(w_ctrl_active_bits);
   assign w_commit      = frame_start_i || !w_ctrl_active.enable;

   vga_csr_shadow_reg #(.WIDTH(CTRL_W), .RESET_VALUE(CTRL_RST)) u_ctrl (
      .i_clk    (clk_i),
      .i_rst    (arst_i),
      .i_we     (w_wr_ctrl),
      .i_wdata  (wdata_i[CTRL_W-1:0]),
      .i_commit (w_commit),
      .o_shadow (w_ctrl_shadow),
      .o_active (w_ctrl_active_bits)
   );

   vga_csr_shadow_reg #(.WIDTH(HACTIVE_W), .RESET_VALUE(HACTIVE_RST)) u_hactive (
      .i_clk    (clk_i),
      .i_rst    (arst_i),
      .i_we     (w_wr_hactive),
      .i_wdata  (wdata_i[HACTIVE_W-1:0]),
      .i_commit (w_commit),
      .o_shadow (w_hactive_shadow),
      .o_active (hactive_o)
   );

   vga_csr_shadow_reg #(.WIDTH(VACTIVE_W), .RESET_VALUE(VACTIVE_RST)) u_vactive (
      .i_clk    (clk_i),
      .i_rst    (arst_i),
      .i_we     (w_wr_vactive),
      .i_wdata  (wdata_i[VACTIVE_W-1:0]),
      .i_commit (w_commit),
      .o_shadow (w_vactive_shadow),
      .o_active (vactive_o)
   );

   assign w_unused_wdata = ^wdata_i[DATA_WIDTH-1:HACTIVE_W];

   always_comb begin
      w_status_set                  = '0;
      w_status_set[STAT_FRAME_DONE] = frame_start_i;
      w_status_set[STAT_UNDERFLOW]  = underflow_i;
      w_status_clr                  = w_wr_status ? wdata_i[STATUS_W-1:0] : '0;
   end

   // Hardware set is OR-ed after the clear so a coincident event is never lost.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_status    <= '0;
         r_frame_cnt <= '0;
         r_irq       <= 1'b0;
      end else begin
         r_status <= (r_status & ~w_status_clr) | w_status_set;
         if (frame_start_i)
            r_frame_cnt <= r_frame_cnt + 32'd1;
         r_irq <= w_ctrl_active.irq_en && (|r_status);
      end
   end

   always_comb begin
      w_rdata_next = '0;
      case (addr_read_i)
         NATIVE_ADDR_WIDTH'(CSR_CTRL):      w_rdata_next = DATA_WIDTH'(w_ctrl_shadow);
         NATIVE_ADDR_WIDTH'(CSR_HACTIVE):   w_rdata_next = DATA_WIDTH'(w_hactive_shadow);
         NATIVE_ADDR_WIDTH'(CSR_VACTIVE):   w_rdata_next = DATA_WIDTH'(w_vactive_shadow);
         NATIVE_ADDR_WIDTH'(CSR_STATUS):    w_rdata_next = DATA_WIDTH'(r_status);
         NATIVE_ADDR_WIDTH'(CSR_FRAME_CNT): w_rdata_next = DATA_WIDTH'(r_frame_cnt);
         NATIVE_ADDR_WIDTH'(CSR_ID):        w_rdata_next = DATA_WIDTH'(ID_VALUE);
         default:                           w_rdata_next = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i)
         r_rdata <= '0;
      else if (read_en_i)
         r_rdata <= w_rdata_next;
   end

   assign rdata_o = r_rdata;
   assign ctrl_o  = w_ctrl_active_bits;
   assign irq_o   = r_irq;

endmodule

// File: tb/tb_vga_csr_bank.sv
// Directed bench for vga_csr_bank: reads are scored through an expectation
// queue drained by a monitor; side-band outputs are compared inline.
module tb_vga_csr_bank;

   localparam logic [31:0] ID_VALUE = 32'h5647_4101;

   logic        clock;
   logic        reset;
   logic        writeEn;
   logic [3:0]  addrWrite;
   logic [31:0] wdata;
   logic        readEn;
   logic [3:0]  addrRead;
   logic [31:0] rdata;
   logic        frameStart;
   logic        underflow;
   logic [2:0]  ctrl;
   logic [11:0] hactive;
   logic [11:0] vactive;
   logic        irq;

   typedef struct {
      string       name;
      logic [31:0] value;
   } expect_t;

   expect_t expQ[$];
   int      checks = 0;
   int      errors = 0;

   vga_csr_bank #(
      .NATIVE_ADDR_WIDTH (4),
      .DATA_WIDTH        (32),
      .ID_VALUE          (ID_VALUE)
   ) dut (
      .clk_i         (clock),
      .arst_i        (reset),
      .write_en_i    (writeEn),
      .addr_write_i  (addrWrite),
      .wdata_i       (wdata),
      .read_en_i     (readEn),
      .addr_read_i   (addrRead),
      .rdata_o       (rdata),
      .frame_start_i (frameStart),
      .underflow_i   (underflow),
      .ctrl_o        (ctrl),
      .hactive_o     (hactive),
      .vactive_o     (vactive),
      .irq_o         (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // One bus cycle; a read pushes its expected data for the monitor.
   task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                input logic re, input logic [3:0] ra, input logic [31:0] rexp,
                                input logic fs, input logic uf, input string name);
      writeEn    = we;
      addrWrite  = wa;
      wdata      = wd;
      readEn     = re;
      addrRead   = ra;
      frameStart = fs;
      underflow  = uf;
      if (re) expQ.push_back('{name, rexp});
      @(posedge clock);
      #1;
      writeEn    = 1'b0;
      readEn     = 1'b0;
      frameStart = 1'b0;
      underflow  = 1'b0;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, "");
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      applyStimulus(1'b1, a, d, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, "");
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] e, input string name);
      applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, a, e, 1'b0, 1'b0, name);
   endtask

   task automatic pulseFrame();
      applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, "");
   endtask

   // Scoreboard monitor: every sampled read strobe owes one queued expectation.
   always @(posedge clock) begin
      if (readEn && !reset) begin
         #1;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_read: got 0x%08h, expected no read", rdata);
         end else begin
            expect_t e;
            e = expQ.pop_front();
            checkOutput(e.name, rdata, e.value);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      writeEn    = 1'b0;
      addrWrite  = '0;
      wdata      = '0;
      readEn     = 1'b0;
      addrRead   = '0;
      frameStart = 1'b0;
      underflow  = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      checkOutput("rst_ctrl", 32'(ctrl), 32'd0);
      checkOutput("rst_hactive", 32'(hactive), 32'd640);
      checkOutput("rst_vactive", 32'(vactive), 32'd480);
      checkOutput("rst_irq", 32'(irq), 32'd0);
      checkOutput("rst_rdata", rdata, 32'd0);

      rd(4'd0, 32'd0, "rd_ctrl_rst");
      rd(4'd1, 32'd640, "rd_hactive_rst");
      rd(4'd2, 32'd480, "rd_vactive_rst");
      rd(4'd3, 32'd0, "rd_status_rst");
      rd(4'd4, 32'd0, "rd_framecnt_rst");
      rd(4'd5, ID_VALUE, "rd_id");
      rd(4'd7, 32'd0, "rd_unmapped");

      // Disabled: writes reach the active copy one cycle later.
      wr(4'd1, 32'h0000_0320);
      checkOutput("hactive_write_edge", 32'(hactive), 32'd640);
      idle();
      checkOutput("hactive_disabled_commit", 32'(hactive), 32'd800);

      wr(4'd0, 32'h0000_0001);
      idle();
      checkOutput("ctrl_enable", 32'(ctrl), 32'd1);

      // Enabled: VACTIVE waits for a frame start.
      wr(4'd2, 32'd600);
      idle();
      checkOutput("vactive_held", 32'(vactive), 32'd480);
      idle();
      checkOutput("vactive_held2", 32'(vactive), 32'd480);
      pulseFrame();
      checkOutput("vactive_frame_commit", 32'(vactive), 32'd600);

      // Same-cycle write and frame start commits the pre-write shadow.
      applyStimulus(1'b1, 4'd2, 32'd768, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, "");
      checkOutput("vactive_same_cycle", 32'(vactive), 32'd600);
      idle();
      checkOutput("vactive_still_old", 32'(vactive), 32'd600);
      pulseFrame();
      checkOutput("vactive_next_frame", 32'(vactive), 32'd768);

      rd(4'd2, 32'd768, "rd_vactive_shadow");
      rd(4'd1, 32'd800, "rd_hactive_shadow");
      rd(4'd3, 32'h1, "rd_status_frame_done");
      rd(4'd4, 32'd3, "rd_framecnt_3");
      checkOutput("irq_masked", 32'(irq), 32'd0);

      wr(4'd3, 32'h1);
      rd(4'd3, 32'h0, "rd_status_cleared");

      // Disable via a frame start, then enable with irq_en while disabled.
      wr(4'd0, 32'h0);
      pulseFrame();
      checkOutput("ctrl_disabled", 32'(ctrl), 32'd0);
      wr(4'd3, 32'h1);
      wr(4'd0, 32'h5);
      idle();
      checkOutput("ctrl_irq_en", 32'(ctrl), 32'd5);
      checkOutput("irq_idle_a", 32'(irq), 32'd0);
      idle();
      checkOutput("irq_idle_b", 32'(irq), 32'd0);

      applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, "");
      checkOutput("irq_lag", 32'(irq), 32'd0);
      idle();
      checkOutput("irq_underflow", 32'(irq), 32'd1);
      rd(4'd3, 32'h2, "rd_status_underflow");

      applyStimulus(1'b1, 4'd3, 32'h2, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, "");
      rd(4'd3, 32'h2, "rd_status_set_wins");
      checkOutput("irq_set_wins", 32'(irq), 32'd1);

      wr(4'd3, 32'h2);
      checkOutput("irq_clear_lag", 32'(irq), 32'd1);
      idle();
      checkOutput("irq_cleared", 32'(irq), 32'd0);
      rd(4'd3, 32'h0, "rd_status_empty");
      rd(4'd4, 32'd4, "rd_framecnt_4");

      // Backdoor the counter next to its wrap point.
      force dut.r_frame_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_frame_cnt;
      pulseFrame();
      rd(4'd4, 32'hFFFF_FFFF, "rd_framecnt_max");
      pulseFrame();
      rd(4'd4, 32'h0, "rd_framecnt_wrap");
      checkOutput("irq_frame_done", 32'(irq), 32'd1);

      applyStimulus(1'b1, 4'd0, 32'h7, 1'b1, 4'd0, 32'h5, 1'b0, 1'b0, "rd_ctrl_pre_write");
      rd(4'd0, 32'h7, "rd_ctrl_post_write");
      checkOutput("ctrl_pending", 32'(ctrl), 32'd5);

      // Asynchronous reset away from any clock edge.
      #2;
      reset = 1'b1;
      #1;
      checkOutput("arst_ctrl", 32'(ctrl), 32'd0);
      checkOutput("arst_hactive", 32'(hactive), 32'd640);
      checkOutput("arst_vactive", 32'(vactive), 32'd480);
      checkOutput("arst_irq", 32'(irq), 32'd0);
      checkOutput("arst_rdata", rdata, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      rd(4'd0, 32'h0, "rd_ctrl_after_arst");
      idle();
      checkOutput("ctrl_no_pending", 32'(ctrl), 32'd0);
      rd(4'd4, 32'h0, "rd_framecnt_after_arst");
      rd(4'd3, 32'h0, "rd_status_after_arst");
      idle();

      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
